// File: rtl/oled_pkg.sv
// Shared types and constants for the OLED controller target: FSM states, opcode masks,
// synchronizer bundle layout and the instruction decoder.
package oled_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_CLEAR = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        OP_NOP      = 3'd0,
        OP_CLEAR    = 3'd1,
        OP_HOME     = 3'd2,
        OP_ENTRY    = 3'd3,
        OP_SET_ADDR = 3'd4
    } op_e;

    localparam logic [7:0] MASK_SET_ADDR = 8'h80;
    localparam logic [7:0] MASK_RESERVED = 8'h78;
    localparam logic [7:0] MASK_ENTRY    = 8'h04;
    localparam logic [7:0] MASK_HOME     = 8'h02;
    localparam logic [7:0] MASK_CLEAR    = 8'h01;
    localparam int         ENTRY_ID_BIT  = 1;

    localparam int DDRAM_DEPTH = 128;
    localparam int SYNC_W      = 11;

    typedef struct packed {
        logic       rs;
        logic       rd;
        logic       en;
        logic [7:0] db;
    } pins_t;

    // Idle bus looks like "read, strobe low" so reset never fakes a falling edge.
    localparam pins_t PINS_RST = '{rs: 1'b0, rd: 1'b1, en: 1'b0, db: 8'h00};

    // Highest set bit selects the instruction; 0x08-0x7F and 0x00 are accepted no-ops.
    function automatic op_e decode_op(input logic [7:0] v);
        if ((v & MASK_SET_ADDR) != 8'h00) return OP_SET_ADDR;
        if ((v & MASK_RESERVED) != 8'h00) return OP_NOP;
        if ((v & MASK_ENTRY) != 8'h00)    return OP_ENTRY;
        if ((v & MASK_HOME) != 8'h00)     return OP_HOME;
        if ((v & MASK_CLEAR) != 8'h00)    return OP_CLEAR;
        return OP_NOP;
    endfunction

endpackage

// File: rtl/oled_sync.sv
// Two-flop synchronizer for a group of asynchronous bus inputs, with a per-bit reset value.
module oled_sync #(
    parameter int             W       = 11,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/oled_target.sv
// Parallel-bus OLED controller target: instruction/data decode, address counter, DDRAM and busy FSM.
// Optional feature: define OLED_TARGET_DATA_READ_EN to serve DDRAM data reads.
module oled_target
    import oled_pkg::*;
#(
    parameter int BUSY_CYCLES  = 240,
    parameter int CLEAR_CYCLES = 12000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rs_pin,
    input  logic       read_pin,
    input  logic       enable_pin,
    input  logic [7:0] db_in,
    output logic [7:0] db_out,
    output logic       db_oe,
    output logic       busy,
    output logic       wr_valid,
    output logic [6:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       clear_pulse,
    output logic       overrun
);

    localparam int CNT_MAX = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    pins_t pins_raw, pins_s;
    assign pins_raw = '{rs: rs_pin, rd: read_pin, en: enable_pin, db: db_in};

    oled_sync #(.W(SYNC_W), .RST_VAL(PINS_RST)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (pins_raw),
        .q     (pins_s)
    );

    // Bus fields captured while E is high; the falling edge acts on these.
    logic       en_d;
    logic       lat_rs, lat_rd;
    logic [7:0] lat_db;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_d   <= 1'b0;
            lat_rs <= 1'b0;
            lat_rd <= 1'b1;
            lat_db <= 8'h00;
        end else begin
            en_d <= pins_s.en;
            if (pins_s.en) begin
                lat_rs <= pins_s.rs;
                lat_rd <= pins_s.rd;
                lat_db <= pins_s.db;
            end
        end
    end

    logic fall, wr_acc, rd_done, is_busy, instr_acc, data_acc, rd_step;
    op_e  op;

    assign fall      = en_d & ~pins_s.en;
    assign wr_acc    = fall & ~lat_rd;
    assign rd_done   = fall & lat_rd;
    assign op        = decode_op(lat_db);
    assign instr_acc = wr_acc & ~is_busy & ~lat_rs;
    assign data_acc  = wr_acc & ~is_busy & lat_rs;
`ifdef OLED_TARGET_DATA_READ_EN
    assign rd_step   = rd_done & lat_rs;
`else
    assign rd_step   = 1'b0;
`endif

    state_e        state, state_nxt;
    logic [CW-1:0] cnt;
    logic          cnt_done;

    assign is_busy  = (state != ST_IDLE);
    assign cnt_done = ((state == ST_BUSY)  && (cnt == CW'(BUSY_CYCLES - 1))) ||
                      ((state == ST_CLEAR) && (cnt == CW'(CLEAR_CYCLES - 1)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= (state == ST_IDLE || cnt_done) ? '0 : cnt + CW'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = is_busy;
        case (state)
            ST_IDLE:  if (instr_acc) state_nxt = (op == OP_CLEAR) ? ST_CLEAR : ST_BUSY;
            ST_BUSY,
            ST_CLEAR: if (cnt_done)  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    logic [6:0] ac;
    logic       id;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ac <= 7'd0;
            id <= 1'b1;
        end else if (instr_acc) begin
            case (op)
                OP_CLEAR:    begin ac <= 7'd0; id <= 1'b1; end
                OP_HOME:     ac <= 7'd0;
                OP_ENTRY:    id <= lat_db[ENTRY_ID_BIT];
                OP_SET_ADDR: ac <= lat_db[6:0];
                default:     ;
            endcase
        end else if (data_acc || rd_step) begin
            ac <= id ? ac + 7'd1 : ac - 7'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_valid    <= 1'b0;
            wr_addr     <= 7'd0;
            wr_data     <= 8'h00;
            clear_pulse <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            wr_valid    <= data_acc;
            clear_pulse <= instr_acc && (op == OP_CLEAR);
            overrun     <= wr_acc & is_busy;
            if (data_acc) begin
                wr_addr <= ac;
                wr_data <= lat_db;
            end
        end
    end

    // DDRAM is not reset; the clear sweep owns it for the first 128 cycles of CLEAR.
    logic [7:0] ddram [DDRAM_DEPTH];
    logic       clr_we;

    assign clr_we = (state == ST_CLEAR) && (cnt < CW'(DDRAM_DEPTH));

    always_ff @(posedge clk) begin
        if (clr_we)
            ddram[cnt[6:0]] <= 8'h00;
        else if (data_acc)
            ddram[ac] <= lat_db;
    end

    assign db_oe = pins_s.rd & pins_s.en;

    always_comb begin
        db_out = 8'h00;
        if (db_oe) begin
            if (!pins_s.rs)
                db_out = {is_busy, ac};
`ifdef OLED_TARGET_DATA_READ_EN
            else
                db_out = ddram[ac];
`endif
        end
    end

endmodule

// File: tb/tb_oled_target.sv
// Randomized self-checking bench for oled_target against a timestamp-based behavioural model.
module tb_oled_target;

    localparam int BUSY_N  = 240;
    localparam int CLEAR_N = 12000;

    logic       clk = 1'b0;
    logic       reset;
    logic       rs_pin, read_pin, enable_pin;
    logic [7:0] db_in;
    logic [7:0] db_out;
    logic       db_oe, busy, wr_valid;
    logic [6:0] wr_addr;
    logic [7:0] wr_data;
    logic       clear_pulse, overrun;

    oled_target #(.BUSY_CYCLES(BUSY_N), .CLEAR_CYCLES(CLEAR_N)) dut (
        .clk         (clk),
        .reset       (reset),
        .rs_pin      (rs_pin),
        .read_pin    (read_pin),
        .enable_pin  (enable_pin),
        .db_in       (db_in),
        .db_out      (db_out),
        .db_oe       (db_oe),
        .busy        (busy),
        .wr_valid    (wr_valid),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .clear_pulse (clear_pulse),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model: AC, I/D, DDRAM mirror, and busy/strobe windows expressed as cycle timestamps.
    int  m_ac = 0;
    bit  m_id = 1'b1;
    int  mem   [128];
    bit  known [128];
    int  bs = 0, be = 0, ps = 0, pe = 0;
    int  oe_from = 0, oe_to = 0;
    int  exp_wr_at = -1, exp_clr_at = -1, exp_ovr_at = -1;
    int  exp_addr = 0, exp_data = 0;
    int  last_addr = -1, last_data = -1;
    bit  chk_en = 1'b0;

    function automatic bit mbusy(input int c);
        return (c >= bs && c < be) || (c >= ps && c < pe);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && chk_en) begin
            check("wr_valid", int'(wr_valid), int'(cyc == exp_wr_at));
            if (wr_valid) begin
                check("wr_addr", int'(wr_addr), exp_addr);
                check("wr_data", int'(wr_data), exp_data);
                last_addr = int'(wr_addr);
                last_data = int'(wr_data);
            end
            check("clear_pulse", int'(clear_pulse), int'(cyc == exp_clr_at));
            check("overrun",     int'(overrun),     int'(cyc == exp_ovr_at));
            check("busy",        int'(busy),        int'(mbusy(cyc)));
            check("db_oe",       int'(db_oe),       int'(cyc >= oe_from && cyc < oe_to));
        end
    end

    task automatic nclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle();
        while (cyc < be || cyc < pe) nclk(1);
        nclk(1);
    endtask

    // Strobe dropped at cycle kf: synchronized edge seen at kf+2, effects visible from kf+3.
    task automatic model_write(input bit rs, input logic [7:0] v, input int kf);
        int a, n;
        a = kf + 3;
        if (mbusy(kf + 2)) begin
            exp_ovr_at = a;
        end else if (rs) begin
            exp_wr_at = a;
            exp_addr  = m_ac;
            exp_data  = int'(v);
            mem[m_ac]   = int'(v);
            known[m_ac] = 1'b1;
            m_ac = m_id ? (m_ac + 1) % 128 : (m_ac + 127) % 128;
        end else begin
            n = BUSY_N;
            if (v >= 8'h80)      m_ac = int'(v) - 128;
            else if (v >= 8'h08) ;
            else if (v >= 8'h04) m_id = v[1];
            else if (v >= 8'h02) m_ac = 0;
            else if (v == 8'h01) begin
                m_ac = 0;
                m_id = 1'b1;
                exp_clr_at = a;
                n = CLEAR_N;
                for (int i = 0; i < 128; i++) begin
                    mem[i] = 0;
                    known[i] = 1'b1;
                end
            end
            ps = bs; pe = be;
            bs = a;  be = a + n;
        end
    endtask

    task automatic do_write(input bit rs, input logic [7:0] v);
        int kf;
        @(negedge clk);
        rs_pin = rs; read_pin = 1'b0; db_in = v; enable_pin = 1'b1;
        nclk(3);
        enable_pin = 1'b0;
        kf = cyc;
        model_write(rs, v, kf);
        nclk(1);
        read_pin = 1'b1;
        nclk(4);
    endtask

    task automatic do_read(input bit rs, input int lit);
        int k0, exp;
        bit do_chk;
        @(negedge clk);
        rs_pin = rs; read_pin = 1'b1; db_in = 8'($urandom); enable_pin = 1'b1;
        k0 = cyc;
        oe_to = 32'h7fff_ffff;
        oe_from = k0 + 2;
        nclk(3);
        do_chk = 1'b1;
        if (!rs) begin
            exp = (mbusy(cyc) ? 128 : 0) + m_ac;
        end else begin
`ifdef OLED_TARGET_DATA_READ_EN
            exp = mem[m_ac];
            do_chk = known[m_ac];
`else
            exp = 0;
`endif
        end
        if (do_chk) check(rs ? "data_read" : "status_read", int'(db_out), exp);
        if (lit >= 0) check(rs ? "data_read_lit" : "status_read_lit", int'(db_out), lit);
        enable_pin = 1'b0;
        oe_to = cyc + 2;
`ifdef OLED_TARGET_DATA_READ_EN
        if (rs) m_ac = m_id ? (m_ac + 1) % 128 : (m_ac + 127) % 128;
`endif
        nclk(5);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},        int'(busy),        0);
        check({tag, "_db_oe"},       int'(db_oe),       0);
        check({tag, "_db_out"},      int'(db_out),      0);
        check({tag, "_wr_valid"},    int'(wr_valid),    0);
        check({tag, "_wr_addr"},     int'(wr_addr),     0);
        check({tag, "_wr_data"},     int'(wr_data),     0);
        check({tag, "_clear_pulse"}, int'(clear_pulse), 0);
        check({tag, "_overrun"},     int'(overrun),     0);
    endtask

    task automatic model_reset();
        m_ac = 0; m_id = 1'b1;
        bs = 0; be = 0; ps = 0; pe = 0;
        oe_from = 0; oe_to = 0;
        exp_wr_at = -1; exp_clr_at = -1; exp_ovr_at = -1;
        for (int i = 0; i < 128; i++) known[i] = 1'b0;
    endtask

    task automatic rand_instr(output logic [7:0] v);
        case ($urandom_range(0, 4))
            0:       v = 8'h80 | 8'($urandom_range(0, 127));
            1:       v = 8'h04 | 8'($urandom_range(0, 3));
            2:       v = 8'h02 | 8'($urandom_range(0, 1));
            3:       v = 8'($urandom_range(8, 127));
            default: v = 8'h00;
        endcase
    endtask

    initial begin
        logic [7:0] v;
        reset = 1'b1; rs_pin = 1'b0; read_pin = 1'b1; enable_pin = 1'b0; db_in = 8'h00;
        model_reset();
        nclk(3);
        check_reset_outputs("por");
        reset = 1'b0;
        chk_en = 1'b1;
        nclk(2);

        // Function set: busy with AC=0, then released.
        do_write(1'b0, 8'h38);
        do_read(1'b0, 8'h80);
        wait_idle();
        do_read(1'b0, 8'h00);

        // Set address 5, two data writes.
        do_write(1'b0, 8'h85);
        wait_idle();
        last_addr = -1; last_data = -1;
        do_write(1'b1, 8'h41);
        check("wr1_addr_lit", last_addr, 5);
        check("wr1_data_lit", last_data, 8'h41);
        do_write(1'b1, 8'h42);
        check("wr2_addr_lit", last_addr, 6);
        check("wr2_data_lit", last_data, 8'h42);
        do_read(1'b0, 8'h07);

        // Decrement mode wraps 0 -> 0x7F.
        do_write(1'b0, 8'h04);
        wait_idle();
        do_write(1'b0, 8'h80);
        wait_idle();
        last_addr = -1;
        do_write(1'b1, 8'h55);
        check("wrap_addr_lit", last_addr, 0);
        do_read(1'b0, 8'h7F);
        do_read(1'b1, -1);

        // Data write during busy is an overrun; AC stays, busy keeps its schedule.
        do_write(1'b0, 8'h06);
        do_write(1'b1, 8'h33);
        do_read(1'b0, 8'hFF);
        wait_idle();
        do_read(1'b0, 8'h7F);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0, 1: do_write(1'b1, 8'($urandom));
                2: begin
                    rand_instr(v);
                    do_write(1'b0, v);
                end
                3: do_read(1'b0, -1);
                4: begin
                    wait_idle();
                    do_write(1'b1, 8'($urandom));
                end
                default: begin
                    wait_idle();
                    do_read(1'b1, -1);
                end
            endcase
        end
        wait_idle();

        // Clear with nonzero DDRAM.
        do_write(1'b0, 8'h80);
        wait_idle();
        do_write(1'b1, 8'hAA);
        do_write(1'b1, 8'hBB);
        do_write(1'b0, 8'h01);
        do_read(1'b0, 8'h80);
        wait_idle();
        do_read(1'b0, 8'h00);
        do_read(1'b1, 8'h00);

        // Reset in the middle of a clear sweep.
        wait_idle();
        do_write(1'b1, 8'h5A);
        do_write(1'b0, 8'h01);
        nclk(50);
        #2 reset = 1'b1;
        #1 check_reset_outputs("mid_clear");
        chk_en = 1'b0;
        model_reset();
        nclk(3);
        reset = 1'b0;
        chk_en = 1'b1;
        nclk(2);
        do_read(1'b0, 8'h00);
        nclk(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
